// File: rtl/muldiv_hilo_if.sv
// Issue/result bundle between the pipeline controller and the HI/LO multiply/divide unit.
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, x, y, input busy, done, hi, lo);
  modport slave  (input start, op, x, y, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_hilo.sv
// Multicycle signed MULT / unsigned DIVU unit owning the HI/LO pair; MTHI/MTLO write directly.
// Optional MULDIV_FAST_MULT_EN: MULT becomes a single-cycle product, DIVU stays iterative.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO complete here in one edge
// RUN    | one shift-add or restoring-divide step per cycle, counter counts down
// DONE   | hi/lo just updated, done pulses for one cycle
module muldiv_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           rst,
  muldiv_hilo_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam int W2 = 2 * WIDTH;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    acc_step;
  logic [W2-1:0]    mul_res;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             op_div;
  logic             neg;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  // acc holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIVU
  always_comb begin
    mul_sum   = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    div_shift = acc[W2-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opb};
    div_ge    = (div_shift >= {1'b0, opb});
    acc_step  = acc;
    if (op_div) begin
      acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
    mul_res = neg ? (~acc_step + W2'(1)) : acc_step;
  end

`ifdef MULDIV_FAST_MULT_EN
  logic signed [W2-1:0] fast_prod;
  assign fast_prod = $signed({{WIDTH{bus.x[WIDTH-1]}}, bus.x}) *
                     $signed({{WIDTH{bus.y[WIDTH-1]}}, bus.y});
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      op_div <= 1'b0;
      neg    <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT: begin
`ifdef MULDIV_FAST_MULT_EN
                hi_q  <= fast_prod[W2-1:WIDTH];
                lo_q  <= fast_prod[WIDTH-1:0];
                state <= S_DONE;
`else
                acc    <= {{WIDTH{1'b0}}, mag(bus.y)};
                opb    <= mag(bus.x);
                neg    <= bus.x[WIDTH-1] ^ bus.y[WIDTH-1];
                op_div <= 1'b0;
                cnt    <= CNT_W'(WIDTH);
                state  <= S_RUN;
`endif
              end
              OP_DIVU: begin
                acc    <= {{WIDTH{1'b0}}, bus.x};
                opb    <= bus.y;
                neg    <= 1'b0;
                op_div <= 1'b1;
                cnt    <= CNT_W'(WIDTH);
                state  <= S_RUN;
              end
              OP_MTHI: hi_q <= bus.x;
              default: lo_q <= bus.x;
            endcase
          end
        end
        S_RUN: begin
          acc <= acc_step;
          cnt <= cnt - CNT_W'(1);
          // final step: commit the result on the same edge that enters DONE
          if (cnt == CNT_W'(1)) begin
            if (op_div) begin
              hi_q <= acc_step[W2-1:WIDTH];
              lo_q <= acc_step[WIDTH-1:0];
            end else begin
              hi_q <= mul_res[W2-1:WIDTH];
              lo_q <= mul_res[WIDTH-1:0];
            end
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: expected HI/LO pushed at issue, popped on each done pulse.
module tb_muldiv_hilo;
  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_hilo_if #(.WIDTH(W)) bus ();
  muldiv_hilo #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  res_t sb[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] p;
    res_t r;
    if (op == 2'b00) begin
      p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      r = p;
    end else if (b == 0) begin
      r = {a, 32'hFFFF_FFFF};
    end else begin
      r = {a % b, a / b};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (!rst && bus.done) begin
      if (sb.size() == 0) check("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("hi", bus.hi, e.hi);
        check("lo", bus.lo, e.lo);
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input res_t exp, input bit inject);
    logic [W-1:0] hi0, lo0;
    int cyc, nbusy, exp_lat, inj_cyc;
    bit seen;
    exp_lat = (FAST && op == 2'b00) ? 1 : W + 1;
    inj_cyc = (exp_lat > 5) ? 5 : exp_lat;
    @(negedge clk);
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.start = 1'b1; bus.op = op; bus.x = a; bus.y = b;
    sb.push_back(exp);
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 0; nbusy = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) nbusy++;
      if (cyc == 3 && !bus.done) check("hold_hilo", {bus.hi, bus.lo}, {hi0, lo0});
      if (inject && cyc == inj_cyc) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.x = 9; bus.y = 3;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) seen = 1'b1;
    end
    if (inject) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("timeout", seen, 1);
    check("latency", cyc, exp_lat);
    check("busy_cycles", nbusy, (exp_lat == 1) ? 0 : W);
    @(negedge clk);
    check("idle_after", {bus.busy, bus.done}, 0);
  endtask

  initial begin
    logic [1:0] rop;
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.x = '0; bus.y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy_done", {bus.busy, bus.done}, 0);
    rst = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, '{32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b0);
    run_op(2'b01, 32'd100, 32'd7, '{32'd2, 32'd14}, 1'b0);
    run_op(2'b01, 32'h1234_5678, 32'd0, '{32'h1234_5678, 32'hFFFF_FFFF}, 1'b0);

    // MTHI then MTLO on back-to-back edges
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.x = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mthi_hi", bus.hi, 32'hDEAD_BEEF);
    check("mthi_lo", bus.lo, 32'hFFFF_FFFF);
    check("mthi_busy_done", {bus.busy, bus.done}, 0);
    bus.op = 2'b11; bus.x = 32'h0BAD_F00D;
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo_lo", bus.lo, 32'h0BAD_F00D);
    check("mtlo_hi", bus.hi, 32'hDEAD_BEEF);
    check("mtlo_busy_done", {bus.busy, bus.done}, 0);

    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, '{32'h4000_0000, 32'h0}, 1'b1);
    repeat (40) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("ignored_req_hi", bus.hi, 32'h4000_0000);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i == 2) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom);
      run_op(rop, ra, rb, model(rop, ra, rb), 1'b0);
    end

    // async reset in the middle of a divide
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.x = 32'd1000; bus.y = 32'd10;
    sb.push_back('{32'd0, 32'd100});
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy_done", {bus.busy, bus.done}, 0);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b01, 32'd1000, 32'd10, '{32'd0, 32'd100}, 1'b0);
    repeat (5) @(negedge clk);
    check("sb_final_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
